spi_rx_engine: RTL and testbench
================================

Name: spi_rx_engine

Overview:
Parametrised SPI master receive path. It deserialises MISO into DATA_WIDTH-bit words at strobes from the SPI clock generator, with runtime MSB/LSB-first order and chip-select framing. Completed words are buffered in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the SPI clock/sample generator and the host-side consumer, replacing the plain 8-bit receive shifter.

Parameters:
DATA_WIDTH, 8, word length in bits (2..32)
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)
CNT_W, $clog2(DATA_WIDTH), bit counter width (derived, not overridden)
LVL_W, $clog2(FIFO_DEPTH+1), FIFO level width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_sample  in  1  single-clk-cycle strobe at the MISO sample point
i_cs_n  in  1  chip select from master FSM, active-low; high = no frame
i_miso  in  1  serial data in, already synchronised
i_lsb_first  in  1  bit order for the next word: 1 = LSB first, 0 = MSB first
o_rx_data  out  DATA_WIDTH  FIFO head word
o_rx_valid  out  1  FIFO non-empty
i_rx_ready  in  1  consumer accepts head when o_rx_valid is high
o_fifo_level  out  LVL_W  words currently stored
o_bit_cnt  out  CNT_W  bits received in the current word
o_overrun  out  1  sticky: a completed word was dropped because the FIFO was full
i_ovr_clr  in  1  clears o_overrun
o_frame_err  out  1  one-cycle pulse: i_cs_n rose with a partial word pending

Behaviour:
- Reset (async, active-high): shift register, bit counter, FIFO pointers and level all cleared; o_rx_data=0, o_rx_valid=0, o_fifo_level=0, o_bit_cnt=0, o_overrun=0, o_frame_err=0. Reset mid-word or mid-FIFO discards all contents.
- Sampling: a bit is shifted only when i_sample=1 and i_cs_n=0. Otherwise i_sample is ignored.
- Bit order: latched into an internal order flag on the sample taken at bit count 0. i_lsb_first changes during a word have no effect until the next word.
- MSB first: shift <= {shift[W-2:0], miso}.
- LSB first: shift <= {miso, shift[W-1:1]}.
- Bit counter: increments per accepted sample and wraps to 0 after bit DATA_WIDTH-1. Back-to-back words within one CS frame are supported without gaps.
- Word completion: on the sample with bit_cnt=DATA_WIDTH-1, the assembled word (including the current bit) is pushed in the same clk edge. o_rx_valid is high from the next cycle, giving 1-cycle latency from the final strobe.
- Frame abort: i_cs_n=1 clears the shift register and bit counter every cycle. If bit_cnt!=0 in the cycle i_cs_n goes high, o_frame_err pulses for exactly 1 cycle and the partial word is discarded (never pushed).
- Simultaneous abort and final sample: i_cs_n=1 wins. The sample is ignored, the word is discarded, and o_frame_err pulses if bit_cnt!=0.
- FIFO is first-word-fall-through:
  - o_rx_data is the head word; o_rx_data is don't-care but stable when empty.
  - A pop occurs on a clk edge where o_rx_valid && i_rx_ready. i_rx_ready while empty is ignored.
  - Level: push only = +1; pop only = -1; push+pop = unchanged.
  - Push+pop when full: the push is accepted and there is no overrun.
  - Push+pop when empty is impossible: valid requires level>0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Overrun: a push when the FIFO is full with no same-cycle pop drops the new word, leaves the FIFO unchanged and sets o_overrun. i_ovr_clr clears it; a set in the same cycle wins over the clear.
- No combinational path from i_miso or i_sample to any output. o_rx_valid and o_fifo_level derive from registers only.

Test Plan:
- MSB-first, DATA_WIDTH=8, CS low, MISO bits 1,0,1,0,0,1,0,1 on 8 strobes -> o_rx_valid rises 1 cycle after the 8th strobe, o_rx_data=0xA5, o_fifo_level=1. Then i_rx_ready=1 for 1 cycle -> valid=0, level=0.
- LSB-first (i_lsb_first=1 before bit 0), same bit sequence -> o_rx_data=0xA5 reversed = 0xA5 (palindrome check); then bits 1,1,0,0,0,0,0,0 -> 0x03. Toggling i_lsb_first at bit 3 of a word does not change that word's result.
- Ready held 0, FIFO_DEPTH=4: 5 words 0x01..0x05 in one frame -> level=4, o_overrun=1 after the 5th, heads pop in order 0x01..0x04, and 0x05 is absent. i_ovr_clr -> o_overrun=0.
- FIFO full, i_rx_ready=1 in the same cycle as the final strobe of 0x06 -> no overrun, level stays 4, and the last entry read out is 0x06.
- CS raised after 3 bits -> o_frame_err=1 for 1 cycle, o_bit_cnt=0, level unchanged. The next frame's 8 bits 0x3C produce exactly 0x3C. CS rise coincident with the 8th strobe -> frame_err pulse and no push.
- Assert reset mid-word (bit_cnt=5) with 2 words buffered -> all outputs 0 immediately (async). After release, a fresh 0x5A is received correctly.

Source files
------------

// File: rtl/spi_rx_engine.sv
// rtl/spi_rx_engine.sv - SPI master receive deserialiser with first-word-fall-through receive FIFO
module spi_rx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(DATA_WIDTH),
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sample,
  input  logic                  i_cs_n,
  input  logic                  i_miso,
  input  logic                  i_lsb_first,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic [LVL_W-1:0]      o_fifo_level,
  output logic [CNT_W-1:0]      o_bit_cnt,
  output logic                  o_overrun,
  input  logic                  i_ovr_clr,
  output logic                  o_frame_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  order_q, order_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  accept;
  logic                  order_eff;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;

  // Bit order is taken live on the first bit of a word, then frozen for the rest of it.
  always_comb begin
    accept    = i_sample && !i_cs_n;
    order_eff = (bit_cnt_q == '0) ? i_lsb_first : order_q;
    shifted   = order_eff ? {i_miso, shift_q[DATA_WIDTH-1:1]}
                          : {shift_q[DATA_WIDTH-2:0], i_miso};
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    order_d     = order_q;
    frame_err_d = i_cs_n && (bit_cnt_q != '0);
    if (i_cs_n) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (accept) begin
      shift_d   = shifted;
      order_d   = order_eff;
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    push     = accept && (bit_cnt_q == LAST_BIT);
    pop      = (level_q != '0) && i_rx_ready;
    full     = (level_q == FULL_LVL);
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overrun_d = overrun_q;
    if (push && full && !pop) begin
      overrun_d = 1'b1;
    end else if (i_ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      order_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      order_q     <= order_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= shifted;
    end
  end

  assign o_rx_data    = mem_q[rd_ptr_q];
  assign o_rx_valid   = (level_q != '0);
  assign o_fifo_level = level_q;
  assign o_bit_cnt    = bit_cnt_q;
  assign o_overrun    = overrun_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_rx_engine.sv
// tb/tb_spi_rx_engine.sv - directed vector bench for spi_rx_engine
module tb_spi_rx_engine;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int CNT_W = 3;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_sample, i_cs_n, i_miso, i_lsb_first, i_rx_ready, i_ovr_clr;
  logic [W-1:0]     o_rx_data;
  logic             o_rx_valid, o_overrun, o_frame_err;
  logic [LVL_W-1:0] o_fifo_level;
  logic [CNT_W-1:0] o_bit_cnt;

  int errors = 0;
  int checks = 0;

  spi_rx_engine #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_sample     (i_sample),
    .i_cs_n       (i_cs_n),
    .i_miso       (i_miso),
    .i_lsb_first  (i_lsb_first),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .i_rx_ready   (i_rx_ready),
    .o_fifo_level (o_fifo_level),
    .o_bit_cnt    (o_bit_cnt),
    .o_overrun    (o_overrun),
    .i_ovr_clr    (i_ovr_clr),
    .o_frame_err  (o_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lsb;
    logic [7:0] seq;
    logic       toggle3;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One strobe: inputs driven on a falling edge, captured on the next rising edge.
  task automatic strobe(input logic b, input logic cs_rise, input logic rdy);
    @(negedge clk);
    i_sample = 1'b1;
    i_miso   = b;
    if (cs_rise) i_cs_n = 1'b1;
    if (rdy) i_rx_ready = 1'b1;
    @(negedge clk);
    i_sample   = 1'b0;
    i_rx_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] seq, input logic lsb, input logic toggle3,
                      input logic rdy_last, input logic abort_last);
    i_lsb_first = lsb;
    for (int i = 0; i < 8; i++) begin
      if (toggle3 && i == 3) i_lsb_first = ~i_lsb_first;
      strobe(seq[7-i], abort_last && (i == 7), rdy_last && (i == 7));
    end
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk({name, " valid"}, 32'(o_rx_valid), 32'd1);
    chk({name, " data"}, 32'(o_rx_data), 32'(exp));
    i_rx_ready = 1'b1;
    @(negedge clk);
    i_rx_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{lsb: 1'b0, seq: 8'hA5, toggle3: 1'b0, exp: 8'hA5};
    vecs[1] = '{lsb: 1'b1, seq: 8'hA5, toggle3: 1'b0, exp: 8'hA5};
    vecs[2] = '{lsb: 1'b1, seq: 8'hC0, toggle3: 1'b0, exp: 8'h03};
    vecs[3] = '{lsb: 1'b0, seq: 8'hC0, toggle3: 1'b1, exp: 8'hC0};
    vecs[4] = '{lsb: 1'b1, seq: 8'hC0, toggle3: 1'b1, exp: 8'h03};
    vecs[5] = '{lsb: 1'b0, seq: 8'h3C, toggle3: 1'b0, exp: 8'h3C};
    vecs[6] = '{lsb: 1'b1, seq: 8'h12, toggle3: 1'b0, exp: 8'h48};

    reset = 1'b1;
    i_sample = 0; i_cs_n = 1; i_miso = 0; i_lsb_first = 0; i_rx_ready = 0; i_ovr_clr = 0;
    repeat (2) @(negedge clk);
    chk("reset valid", 32'(o_rx_valid), 32'd0);
    chk("reset data", 32'(o_rx_data), 32'd0);
    chk("reset level", 32'(o_fifo_level), 32'd0);
    chk("reset bitcnt", 32'(o_bit_cnt), 32'd0);
    chk("reset overrun", 32'(o_overrun), 32'd0);
    chk("reset frame_err", 32'(o_frame_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      i_cs_n = 1'b0;
      send(vecs[v].seq, vecs[v].lsb, vecs[v].toggle3, 1'b0, 1'b0);
      chk($sformatf("vec%0d level", v), 32'(o_fifo_level), 32'd1);
      pop_check($sformatf("vec%0d", v), vecs[v].exp);
      chk($sformatf("vec%0d valid after pop", v), 32'(o_rx_valid), 32'd0);
      chk($sformatf("vec%0d level after pop", v), 32'(o_fifo_level), 32'd0);
      i_cs_n = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d no frame_err", v), 32'(o_frame_err), 32'd0);
    end

    // Overrun with ready held low
    i_cs_n = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 4) begin
        chk("ovr level4", 32'(o_fifo_level), 32'd4);
        chk("ovr not yet", 32'(o_overrun), 32'd0);
      end
    end
    chk("ovr set", 32'(o_overrun), 32'd1);
    chk("ovr level held", 32'(o_fifo_level), 32'd4);
    for (int k = 1; k <= 4; k++) pop_check($sformatf("ovr pop%0d", k), 8'(k));
    chk("ovr drained", 32'(o_rx_valid), 32'd0);
    chk("ovr sticky", 32'(o_overrun), 32'd1);
    i_ovr_clr = 1'b1;
    @(negedge clk);
    i_ovr_clr = 1'b0;
    chk("ovr cleared", 32'(o_overrun), 32'd0);

    // Push and pop together while full
    for (int k = 1; k <= 4; k++) send(8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fullpp level before", 32'(o_fifo_level), 32'd4);
    send(8'h06, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fullpp level", 32'(o_fifo_level), 32'd4);
    chk("fullpp no overrun", 32'(o_overrun), 32'd0);
    pop_check("fullpp pop2", 8'h02);
    pop_check("fullpp pop3", 8'h03);
    pop_check("fullpp pop4", 8'h04);
    pop_check("fullpp pop6", 8'h06);
    chk("fullpp empty", 32'(o_rx_valid), 32'd0);

    // Frame abort after 3 bits
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("abort bitcnt3", 32'(o_bit_cnt), 32'd3);
    i_cs_n = 1'b1;
    @(negedge clk);
    chk("abort frame_err", 32'(o_frame_err), 32'd1);
    chk("abort bitcnt0", 32'(o_bit_cnt), 32'd0);
    chk("abort level", 32'(o_fifo_level), 32'd0);
    @(negedge clk);
    chk("abort pulse end", 32'(o_frame_err), 32'd0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("cs high ignores sample", 32'(o_bit_cnt), 32'd0);

    // Next frame 0x3C, checking latency around the final strobe
    i_cs_n = 1'b0;
    i_lsb_first = 1'b0;
    for (int i = 0; i < 7; i++) strobe(((8'h3C >> (7 - i)) & 8'h01) != 0, 1'b0, 1'b0);
    chk("3c bitcnt7", 32'(o_bit_cnt), 32'd7);
    chk("3c not valid yet", 32'(o_rx_valid), 32'd0);
    strobe(1'b0, 1'b0, 1'b0);
    chk("3c level", 32'(o_fifo_level), 32'd1);
    chk("3c bitcnt wrap", 32'(o_bit_cnt), 32'd0);
    pop_check("3c", 8'h3C);

    // CS rise coincident with the 8th strobe
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("coinc frame_err", 32'(o_frame_err), 32'd1);
    chk("coinc no push", 32'(o_fifo_level), 32'd0);
    chk("coinc not valid", 32'(o_rx_valid), 32'd0);
    @(negedge clk);
    chk("coinc pulse end", 32'(o_frame_err), 32'd0);

    // Reset mid-word with two words buffered
    i_cs_n = 1'b0;
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0);
    chk("rst level2", 32'(o_fifo_level), 32'd2);
    chk("rst bitcnt5", 32'(o_bit_cnt), 32'd5);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst async valid", 32'(o_rx_valid), 32'd0);
    chk("rst async data", 32'(o_rx_data), 32'd0);
    chk("rst async level", 32'(o_fifo_level), 32'd0);
    chk("rst async bitcnt", 32'(o_bit_cnt), 32'd0);
    chk("rst async frame_err", 32'(o_frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post rst level", 32'(o_fifo_level), 32'd1);
    pop_check("post rst", 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
